pattern_sequencer: RTL

//  Frame/line timing and schedule controller for the pattern generator top.

---
 rtl/pattern_sequencer_if.sv | 30 +++
 rtl/pattern_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer_if.sv
// Control, table-write and pattern-output bundle between the pattern sequencer and its host.
// The master side drives requests and table writes; the slave side drives timing and pattern outputs.
interface pattern_sequencer_if;
    logic        start;
    logic        stop;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [18:0] wr_data;
    logic [1:0]  last_entry;
    logic [3:0]  frames_per_entry;
    logic        f_sync;
    logic        sync;
    logic [2:0]  Mode;
    logic [1:0]  X;
    logic [1:0]  Y;
    logic [11:0] constVal;
    logic [1:0]  entry_idx;
    logic        busy;
    logic        frame_done;

    modport master (
        output start, stop, wr_en, wr_addr, wr_data, last_entry, frames_per_entry,
        input  f_sync, sync, Mode, X, Y, constVal, entry_idx, busy, frame_done
    );

    modport slave (
        input  start, stop, wr_en, wr_addr, wr_data, last_entry, frames_per_entry,
        output f_sync, sync, Mode, X, Y, constVal, entry_idx, busy, frame_done
    );
endinterface

// File: rtl/pattern_sequencer.sv
// Frame/line timing and 4-entry schedule controller for the pattern generator.
// Emits f_sync/sync pulses and holds pattern settings constant for whole frames.
module pattern_sequencer #(
    parameter int unsigned LINE_PIX = 4096,
    parameter int unsigned LINES    = 32,
    parameter int unsigned HBLANK   = 8,
    parameter int unsigned VBLANK   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pattern_sequencer_if.slave    io_bus
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSync   = 3'd1;
    localparam logic [2:0] StActive = 3'd2;
    localparam logic [2:0] StHblk   = 3'd3;
    localparam logic [2:0] StVblk   = 3'd4;

    localparam bit          HasHblk   = (HBLANK > 0);
    localparam bit          HasVblk   = (VBLANK > 0);
    localparam logic [11:0] PixLast   = 12'(LINE_PIX - 1);
    localparam logic [11:0] HblkLast  = HasHblk ? 12'(HBLANK - 1) : 12'd0;
    localparam logic [11:0] VblkLast  = HasVblk ? 12'(VBLANK - 1) : 12'd0;
    localparam logic [4:0]  LinesLast = 5'(LINES - 1);

    logic [2:0]  r_state;
    logic [11:0] r_cnt;
    logic [4:0]  r_line;
    logic [3:0]  r_fcnt;
    logic [1:0]  r_entry;
    logic [18:0] r_out;
    logic        r_stop_pend;
    logic        r_sync;
    logic        r_f_sync;
    logic        r_busy;
    logic        r_frame_done;
    logic [18:0] r_table [4];

    logic [2:0]  w_state_d;
    logic [11:0] w_cnt_d;
    logic [4:0]  w_line_d;
    logic [3:0]  w_fcnt_d;
    logic [1:0]  w_entry_d;
    logic [18:0] w_out_d;
    logic        w_stop_pend_d;
    logic [4:0]  w_fcnt_inc;
    logic [4:0]  w_fpe;
    logic [1:0]  w_next_entry;

    // A line ends on the last ACTIVE cycle when there is no horizontal blank.
    function automatic logic f_line_end(input logic [2:0] st, input logic [11:0] cnt);
        return ((st == StActive) && (cnt == PixLast) && !HasHblk) ||
               ((st == StHblk) && (cnt == HblkLast));
    endfunction

    function automatic logic f_frame_end(input logic [2:0] st, input logic [11:0] cnt,
                                         input logic [4:0] line);
        return ((st == StVblk) && (cnt == VblkLast)) ||
               (f_line_end(st, cnt) && (line == LinesLast) && !HasVblk);
    endfunction

    assign w_fcnt_inc   = {1'b0, r_fcnt} + 5'd1;
    assign w_fpe        = (io_bus.frames_per_entry == 4'd0) ? 5'd1
                                                            : {1'b0, io_bus.frames_per_entry};
    assign w_next_entry = (r_entry >= io_bus.last_entry) ? 2'd0 : r_entry + 2'd1;

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_line_d      = r_line;
        w_fcnt_d      = r_fcnt;
        w_entry_d     = r_entry;
        w_out_d       = r_out;
        w_stop_pend_d = r_stop_pend | (io_bus.stop & r_busy);

        if (f_frame_end(r_state, r_cnt, r_line)) begin
            w_line_d = 5'd0;
            w_cnt_d  = 12'd0;
            if (w_fcnt_inc >= w_fpe) begin
                w_fcnt_d  = 4'd0;
                w_entry_d = w_next_entry;
            end else begin
                w_fcnt_d = w_fcnt_inc[3:0];
            end
            // Reload reads the table before any same-edge write lands.
            w_out_d = r_table[w_entry_d];
            if (r_stop_pend) begin
                w_state_d     = StIdle;
                w_stop_pend_d = 1'b0;
            end else begin
                w_state_d = StSync;
            end
        end else if (f_line_end(r_state, r_cnt)) begin
            w_cnt_d = 12'd0;
            if (r_line == LinesLast) begin
                w_state_d = StVblk;
            end else begin
                w_line_d  = r_line + 5'd1;
                w_state_d = StSync;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        w_state_d     = StSync;
                        w_cnt_d       = 12'd0;
                        w_line_d      = 5'd0;
                        w_fcnt_d      = 4'd0;
                        w_entry_d     = 2'd0;
                        w_out_d       = r_table[0];
                        w_stop_pend_d = 1'b0;
                    end
                end
                StSync: begin
                    w_state_d = StActive;
                    w_cnt_d   = 12'd0;
                end
                StActive: begin
                    if (r_cnt == PixLast) begin
                        w_state_d = StHblk;
                        w_cnt_d   = 12'd0;
                    end else begin
                        w_cnt_d = r_cnt + 12'd1;
                    end
                end
                StHblk, StVblk: begin
                    w_cnt_d = r_cnt + 12'd1;
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= 12'd0;
            r_line       <= 5'd0;
            r_fcnt       <= 4'd0;
            r_entry      <= 2'd0;
            r_out        <= 19'd0;
            r_stop_pend  <= 1'b0;
            r_sync       <= 1'b0;
            r_f_sync     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_table[i] <= 19'd0;
            end
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_line       <= w_line_d;
            r_fcnt       <= w_fcnt_d;
            r_entry      <= w_entry_d;
            r_out        <= w_out_d;
            r_stop_pend  <= w_stop_pend_d;
            // Pulse outputs are decoded from the next state so they stay registered.
            r_sync       <= (w_state_d == StSync);
            r_f_sync     <= (w_state_d == StSync) && (w_line_d == 5'd0);
            r_busy       <= (w_state_d != StIdle);
            r_frame_done <= f_frame_end(w_state_d, w_cnt_d, w_line_d);
            if (io_bus.wr_en) begin
                r_table[io_bus.wr_addr] <= io_bus.wr_data;
            end
        end
    end

    assign io_bus.sync       = r_sync;
    assign io_bus.f_sync     = r_f_sync;
    assign io_bus.busy       = r_busy;
    assign io_bus.frame_done = r_frame_done;
    assign io_bus.entry_idx  = r_entry;
    assign io_bus.Mode       = r_out[18:16];
    assign io_bus.Y          = r_out[15:14];
    assign io_bus.X          = r_out[13:12];
    assign io_bus.constVal   = r_out[11:0];

endmodule
